control_queue: RTL and testbench
================================

// Module: control_queue
// PURPOSE
//   Per-player direction control for the snake game, successor to the single-player
//   direction register. It detects button presses on N_PLAYERS independent pads and
//   holds legal turns in a per-player FIFO, so fast double-taps between moves are kept.
//   It applies one queued turn per movement step (i_step) to drive each snake's heading.
// PARAMETERS
//   N_PLAYERS   1      number of independent players/snakes (>=1)
//   QUEUE_DEPTH 2      turn FIFO entries per player (>=1; power of two not required)
//   RESET_DIR   2'b01  heading loaded on reset/clear (encoding: 00 up, 01 down, 10 left, 11 right)
// PORTS
//   clk               in   1     system clock, all state on rising edge
//   rst_n             in   1     asynchronous active-low reset
//   i_clear           in   1     synchronous clear (new game); same effect as reset
//   i_step            in   1     movement tick; one-cycle pulse, shared by all players
//   i_up              in   N     per-player button, level, already synchronised upstream
//   i_down            in   N     "
//   i_left            in   N     "
//   i_right           in   N     "
//   i_head_dir        in   2N    actual current head direction of each snake, player p at [2p+1:2p]
//   o_dir             out  2N    applied heading per player
//   o_start           out  N     sticky: player has steered away from RESET_DIR
//   o_new_user_input  out  N     player FIFO non-empty (a turn is pending)
//   o_drop            out  N     1-cycle pulse: a legal press was discarded (FIFO full)
// BEHAVIOUR
//   Reset/clear: o_dir=RESET_DIR for every player, FIFOs empty, o_start=0, o_drop=0, edge regs=0.
//   - A button already held at reset release therefore registers as a press on the first cycle.
//   - i_clear has priority over every other input in that cycle.
//   Edge detect: press_x = i_x & ~prev_x. prev_x is registered every cycle.
//   Candidate: if several presses occur in one cycle, priority is up > down > left > right.
//   - Only the highest-priority press is considered; the others are ignored (no drop pulse).
//   Reverse(d) = {d[1], ~d[0]}. ref = newest FIFO entry if the FIFO is non-empty, else o_dir.
//   Enqueue: the candidate is accepted iff cand != ref and cand != Reverse(ref).
//   - A rejected candidate produces no effect and no o_drop.
//   - Accepted candidate with FIFO full and no pop this cycle: discarded, o_drop=1 next cycle.
//   - Accepted candidate with FIFO full and a pop this cycle: enqueued, count unchanged.
//   Dequeue on i_step, using the FIFO state before this cycle's push:
//   - Empty FIFO: o_dir holds.
//   - head == Reverse(i_head_dir[p]): entry popped and discarded, o_dir holds.
//   - Otherwise: o_dir <= head, entry popped.
//   - A push into an empty FIFO in the same cycle as i_step is not applied until the next step.
//   Latency: press at cycle t -> o_new_user_input=1 at t+1. i_step at t+1 -> o_dir updates at t+2.
//   o_start[p] <= o_start[p] | (o_dir[p] != RESET_DIR). It is set 1 cycle after the first
//   heading change and held until reset/clear.
//   Players are fully independent; only i_step and i_clear are shared.
//   FIFO: read/write pointers wrap modulo QUEUE_DEPTH, count 0..QUEUE_DEPTH.
//   - The newest-entry read uses the write pointer minus 1, modulo QUEUE_DEPTH.
// TESTING
//   1 Reset, N=1, D=2, RESET_DIR=01: o_dir=01, o_start=0, o_new_user_input=0; press up
//     -> rejected (reverse of down), queue stays empty.
//   2 Press left, then right (tail left -> right rejected), then up -> queue {10,00};
//     i_step x2 -> o_dir 10 then 00; o_start=1 the cycle after o_dir=10.
//   3 D=2: press left, up, right in distinct cycles with no step -> third press dropped,
//     o_drop pulses once; then i_step pops 10.
//   4 Queue full + press + i_step in the same cycle -> count stays 2, new entry kept, no drop.
//   5 Queue {10}, i_head_dir=11, i_step -> entry discarded, o_dir unchanged, queue empty.
//   6 N=2: simultaneous presses on both players + mid-sequence i_clear -> independent queues;
//     clear restores all reset values next cycle. Assert rst_n low asynchronously mid-step
//     -> outputs reset immediately.

Source files
------------

// File: rtl/control_queue.sv
// Per-player snake direction control: button edge detection, a small turn FIFO per
// player, and one applied turn per movement step.
module control_queue #(
  parameter int         N_PLAYERS   = 1,
  parameter int         QUEUE_DEPTH = 2,
  parameter logic [1:0] RESET_DIR   = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_step,
  input  logic [N_PLAYERS-1:0]   i_up,
  input  logic [N_PLAYERS-1:0]   i_down,
  input  logic [N_PLAYERS-1:0]   i_left,
  input  logic [N_PLAYERS-1:0]   i_right,
  input  logic [2*N_PLAYERS-1:0] i_head_dir,
  output logic [2*N_PLAYERS-1:0] o_dir,
  output logic [N_PLAYERS-1:0]   o_start,
  output logic [N_PLAYERS-1:0]   o_new_user_input,
  output logic [N_PLAYERS-1:0]   o_drop
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_IDX) ? PW'(0) : ptr + PW'(1);
  endfunction

  logic [N_PLAYERS-1:0] prev_up, prev_down, prev_left, prev_right;
  logic [N_PLAYERS-1:0] press_up, press_down, press_left, press_right;

  assign press_up    = i_up    & ~prev_up;
  assign press_down  = i_down  & ~prev_down;
  assign press_left  = i_left  & ~prev_left;
  assign press_right = i_right & ~prev_right;

  // Previous button levels for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_up    <= '0;
      prev_down  <= '0;
      prev_left  <= '0;
      prev_right <= '0;
    end else if (i_clear) begin
      prev_up    <= '0;
      prev_down  <= '0;
      prev_left  <= '0;
      prev_right <= '0;
    end else begin
      prev_up    <= i_up;
      prev_down  <= i_down;
      prev_left  <= i_left;
      prev_right <= i_right;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [1:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, newest_idx;
    logic [CW-1:0] count, count_next;
    logic [1:0]    dir, dir_next, cand, ref_dir, head;
    logic          cand_valid, accept, push, pop, empty, full;
    logic          start, drop, nonempty;

    // Candidate selection, legality against the newest heading, FIFO push/pop decisions
    always_comb begin
      cand_valid = 1'b0;
      cand       = 2'b00;
      if (press_up[p]) begin
        cand_valid = 1'b1;
        cand       = 2'b00;
      end else if (press_down[p]) begin
        cand_valid = 1'b1;
        cand       = 2'b01;
      end else if (press_left[p]) begin
        cand_valid = 1'b1;
        cand       = 2'b10;
      end else if (press_right[p]) begin
        cand_valid = 1'b1;
        cand       = 2'b11;
      end else begin
        cand_valid = 1'b0;
        cand       = 2'b00;
      end

      empty      = (count == CW'(0));
      full       = (count == FULL_CNT);
      newest_idx = (wr_ptr == PW'(0)) ? LAST_IDX : wr_ptr - PW'(1);
      ref_dir    = empty ? dir : mem[newest_idx];
      head       = mem[rd_ptr];

      accept = cand_valid && (cand != ref_dir) && (cand != reverse_dir(ref_dir));
      pop    = i_step && !empty;
      push   = accept && (!full || pop);

      // A queued turn that would now reverse into the body is silently dropped
      if (pop && (head != reverse_dir(i_head_dir[2*p +: 2]))) begin
        dir_next = head;
      end else begin
        dir_next = dir;
      end

      if (push && !pop) begin
        count_next = count + CW'(1);
      end else if (!push && pop) begin
        count_next = count - CW'(1);
      end else begin
        count_next = count;
      end
    end

    // Per-player FIFO, heading, sticky start and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= 2'b00;
        rd_ptr   <= PW'(0);
        wr_ptr   <= PW'(0);
        count    <= CW'(0);
        dir      <= RESET_DIR;
        start    <= 1'b0;
        drop     <= 1'b0;
        nonempty <= 1'b0;
      end else if (i_clear) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= 2'b00;
        rd_ptr   <= PW'(0);
        wr_ptr   <= PW'(0);
        count    <= CW'(0);
        dir      <= RESET_DIR;
        start    <= 1'b0;
        drop     <= 1'b0;
        nonempty <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= cand;
          wr_ptr      <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        count    <= count_next;
        nonempty <= (count_next != CW'(0));
        dir      <= dir_next;
        start    <= start | (dir != RESET_DIR);
        drop     <= accept && full && !pop;
      end
    end

    assign o_dir[2*p +: 2]     = dir;
    assign o_start[p]          = start;
    assign o_new_user_input[p] = nonempty;
    assign o_drop[p]           = drop;
  end

endmodule

// File: tb/tb_control_queue.sv
// Randomised and directed bench for control_queue (2 players, depth 2) against a
// queue-level reference model.
module tb_control_queue;

  localparam int         N   = 2;
  localparam int         D   = 2;
  localparam logic [1:0] RST = 2'b01;

  logic           clk;
  logic           rst_n;
  logic           i_clear;
  logic           i_step;
  logic [N-1:0]   i_up, i_down, i_left, i_right;
  logic [2*N-1:0] i_head_dir;
  logic [2*N-1:0] o_dir;
  logic [N-1:0]   o_start, o_new_user_input, o_drop;

  int checks = 0;
  int errors = 0;

  // reference model: shift-register FIFO per player
  logic [1:0] m_q     [N][D];
  int         m_cnt   [N];
  logic [1:0] m_dir   [N];
  logic       m_start [N];
  logic       m_drop  [N];
  logic [3:0] m_prev  [N];

  control_queue #(
    .N_PLAYERS  (N),
    .QUEUE_DEPTH(D),
    .RESET_DIR  (RST)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (i_clear),
    .i_step          (i_step),
    .i_up            (i_up),
    .i_down          (i_down),
    .i_left          (i_left),
    .i_right         (i_right),
    .i_head_dir      (i_head_dir),
    .o_dir           (o_dir),
    .o_start         (o_start),
    .o_new_user_input(o_new_user_input),
    .o_drop          (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] rev(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_cnt[p]   = 0;
      m_dir[p]   = RST;
      m_start[p] = 1'b0;
      m_drop[p]  = 1'b0;
      m_prev[p]  = 4'b0000;
      for (int k = 0; k < D; k++) m_q[p][k] = 2'b00;
    end
  endtask

  task automatic model_update();
    logic [3:0] btn;
    logic       cv, acc, popn;
    logic [1:0] cd, rf, head;
    for (int p = 0; p < N; p++) begin
      btn = {i_right[p], i_left[p], i_down[p], i_up[p]} & ~m_prev[p];
      cv = 1'b1;
      cd = 2'b00;
      if (btn[0]) cd = 2'b00;
      else if (btn[1]) cd = 2'b01;
      else if (btn[2]) cd = 2'b10;
      else if (btn[3]) cd = 2'b11;
      else cv = 1'b0;
      rf   = (m_cnt[p] > 0) ? m_q[p][m_cnt[p]-1] : m_dir[p];
      acc  = cv && (cd != rf) && (cd != rev(rf));
      popn = i_step && (m_cnt[p] > 0);
      head = m_q[p][0];
      m_start[p] = m_start[p] | (m_dir[p] != RST);
      if (popn && head != rev(i_head_dir[2*p +: 2])) m_dir[p] = head;
      if (popn) begin
        for (int k = 0; k < D-1; k++) m_q[p][k] = m_q[p][k+1];
        m_cnt[p]--;
      end
      m_drop[p] = 1'b0;
      if (acc) begin
        if (m_cnt[p] < D) begin
          m_q[p][m_cnt[p]] = cd;
          m_cnt[p]++;
        end else begin
          m_drop[p] = 1'b1;
        end
      end
      m_prev[p] = {i_right[p], i_left[p], i_down[p], i_up[p]};
    end
    if (i_clear) model_reset();
  endtask

  task automatic compare_model(input string tag);
    logic [2*N-1:0] ed;
    logic [N-1:0]   es, en, ep;
    for (int p = 0; p < N; p++) begin
      ed[2*p +: 2] = m_dir[p];
      es[p] = m_start[p];
      en[p] = (m_cnt[p] > 0);
      ep[p] = m_drop[p];
    end
    check_val({tag, "_dir"},   32'(o_dir), 32'(ed));
    check_val({tag, "_start"}, 32'(o_start), 32'(es));
    check_val({tag, "_nui"},   32'(o_new_user_input), 32'(en));
    check_val({tag, "_drop"},  32'(o_drop), 32'(ep));
  endtask

  task automatic cycle(input string tag);
    model_update();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic release_all();
    i_up = '0; i_down = '0; i_left = '0; i_right = '0;
    i_step = 1'b0; i_clear = 1'b0;
  endtask

  task automatic set_btn(input int p, input logic [1:0] d);
    case (d)
      2'b00:   i_up[p]    = 1'b1;
      2'b01:   i_down[p]  = 1'b1;
      2'b10:   i_left[p]  = 1'b1;
      2'b11:   i_right[p] = 1'b1;
      default: i_up[p]    = 1'b0;
    endcase
  endtask

  task automatic hd_follow();
    for (int p = 0; p < N; p++) i_head_dir[2*p +: 2] = m_dir[p];
  endtask

  task automatic tap(input string tag, input int p, input logic [1:0] d, input logic stp);
    release_all();
    hd_follow();
    set_btn(p, d);
    i_step = stp;
    cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    release_all();
    i_head_dir = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    hd_follow();
    check_val("rst_dir",   32'(o_dir), 32'h5);
    check_val("rst_start", 32'(o_start), 32'h0);
    check_val("rst_nui",   32'(o_new_user_input), 32'h0);

    // 1: up is the reverse of the reset heading
    tap("s1_up", 0, 2'b00, 1'b0);
    check_val("s1_nui", 32'(o_new_user_input[0]), 32'h0);
    release_all(); cycle("s1_rel");

    // 2: left accepted, right rejected against tail, up accepted, two steps
    tap("s2_left", 0, 2'b10, 1'b0);
    check_val("s2_nui", 32'(o_new_user_input[0]), 32'h1);
    release_all(); cycle("s2_rel");
    tap("s2_right", 0, 2'b11, 1'b0); release_all(); cycle("s2_rel");
    tap("s2_up", 0, 2'b00, 1'b0);    release_all(); cycle("s2_rel");
    release_all(); hd_follow(); i_step = 1'b1; cycle("s2_step1");
    check_val("s2_dir1",   32'(o_dir[1:0]), 32'h2);
    check_val("s2_start1", 32'(o_start[0]), 32'h0);
    release_all(); hd_follow(); i_step = 1'b1; cycle("s2_step2");
    check_val("s2_dir2",   32'(o_dir[1:0]), 32'h0);
    check_val("s2_start2", 32'(o_start[0]), 32'h1);

    // 3: fill queue then overflow
    tap("s3_left", 0, 2'b10, 1'b0); release_all(); cycle("s3_rel");
    tap("s3_up", 0, 2'b00, 1'b0);   release_all(); cycle("s3_rel");
    tap("s3_right", 0, 2'b11, 1'b0);
    check_val("s3_drop", 32'(o_drop[0]), 32'h1);
    release_all(); cycle("s3_rel");
    check_val("s3_drop_end", 32'(o_drop[0]), 32'h0);
    release_all(); hd_follow(); i_step = 1'b1; cycle("s3_step");
    check_val("s3_dir", 32'(o_dir[1:0]), 32'h2);

    // 4: full queue with simultaneous press and step
    tap("s4_left", 0, 2'b10, 1'b0); release_all(); cycle("s4_rel");
    tap("s4_up_step", 0, 2'b00, 1'b1);
    check_val("s4_nui",  32'(o_new_user_input[0]), 32'h1);
    check_val("s4_drop", 32'(o_drop[0]), 32'h0);
    check_val("s4_dir",  32'(o_dir[1:0]), 32'h0);
    release_all(); cycle("s4_rel");

    // 5: queued turn reverses into the body and is discarded
    release_all(); i_clear = 1'b1; cycle("s5_clr");
    tap("s5_left", 0, 2'b10, 1'b0); release_all(); cycle("s5_rel");
    release_all(); hd_follow(); i_head_dir[1:0] = 2'b11; i_step = 1'b1; cycle("s5_step");
    check_val("s5_dir", 32'(o_dir[1:0]), 32'h1);
    check_val("s5_nui", 32'(o_new_user_input[0]), 32'h0);

    // 6: two players, then clear with buttons held
    release_all(); hd_follow(); i_left = 2'b01; i_right = 2'b10; cycle("s6_press");
    check_val("s6_nui", 32'(o_new_user_input), 32'h3);
    release_all(); cycle("s6_rel");
    release_all(); hd_follow(); i_step = 1'b1; cycle("s6_step");
    check_val("s6_dir", 32'(o_dir), 32'hE);
    release_all(); i_left = 2'b11; cycle("s6_q");
    release_all(); i_clear = 1'b1; i_up = 2'b11; cycle("s6_clr");
    check_val("s6_clr_dir",   32'(o_dir), 32'h5);
    check_val("s6_clr_nui",   32'(o_new_user_input), 32'h0);
    check_val("s6_clr_start", 32'(o_start), 32'h0);

    // async reset in the middle of a stepping cycle, button held across release
    release_all(); i_right = 2'b11; cycle("ar_q");
    release_all(); i_step = 1'b1; hd_follow();
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_dir",   32'(o_dir), 32'h5);
    check_val("ar_nui",   32'(o_new_user_input), 32'h0);
    check_val("ar_start", 32'(o_start), 32'h0);
    check_val("ar_drop",  32'(o_drop), 32'h0);
    model_reset();
    release_all();
    i_left = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("ar_held");
    check_val("ar_held_nui", 32'(o_new_user_input), 32'h3);

    // randomised phase
    for (int c = 0; c < 600; c++) begin
      i_up    = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      i_down  = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      i_left  = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      i_right = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
      i_step  = ($urandom_range(0, 3) == 0);
      i_clear = ($urandom_range(0, 79) == 0);
      hd_follow();
      if ($urandom_range(0, 3) == 0) i_head_dir = (2*N)'($urandom);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
